// File: rtl/conv2d_3x3_stream.sv
// rtl/conv2d_3x3_stream.sv - streaming 3x3 convolution with zero-padded borders, shift and saturation
// Two line buffers feed a 3x3 window; output n is registered on the step that consumes input n+IMG_W+1.
module conv2d_3x3_stream #(
  parameter int IMG_W      = 128,
  parameter int IMG_H      = 128,
  parameter int PIXEL_BITS = 8,
  parameter int COEF_BITS  = 8,
  parameter int SHIFT      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [PIXEL_BITS-1:0] s_data,
  input  logic                  coef_we,
  input  logic [3:0]            coef_addr,
  input  logic [COEF_BITS-1:0]  coef_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [PIXEL_BITS-1:0] m_data,
  output logic                  m_last
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int FW = $clog2(IMG_W + 2);
  localparam int SW = PIXEL_BITS + COEF_BITS + 5;
  localparam int PMAX = (1 << PIXEL_BITS) - 1;
  localparam int SOBEL_X [9] = '{1, 0, -1, 2, 0, -2, 1, 0, -1};

  typedef enum logic {RUN, FLUSH} state_t;

  state_t                       state;
  logic [CW-1:0]                in_col, out_col;
  logic [RW-1:0]                in_row, out_row;
  logic [FW-1:0]                fill;
  logic [PIXEL_BITS-1:0]        lb0 [IMG_W];
  logic [PIXEL_BITS-1:0]        lb1 [IMG_W];
  logic [PIXEL_BITS-1:0]        win_l [3];
  logic [PIXEL_BITS-1:0]        win_c [3];
  logic [PIXEL_BITS-1:0]        win_r [3];
  logic signed [COEF_BITS-1:0]  coef [9];
  logic                         adv, step, produce, in_last, out_last;
  logic [PIXEL_BITS-1:0]        pix;
  logic signed [SW-1:0]         sum, res;
  logic [PIXEL_BITS-1:0]        sat;

  assign adv      = !m_valid || m_ready;
  assign step     = adv && ((state == RUN && s_valid) || state == FLUSH);
  assign s_ready  = (state == RUN) && adv;
  assign pix      = (state == RUN) ? s_data : '0;
  assign produce  = step && (fill == FW'(IMG_W + 1));
  assign in_last  = (in_col == CW'(IMG_W - 1)) && (in_row == RW'(IMG_H - 1));
  assign out_last = (out_col == CW'(IMG_W - 1)) && (out_row == RW'(IMG_H - 1));

  // Incoming column, top to bottom: two lines ago, previous line, current pixel.
  assign win_r[0] = lb1[in_col];
  assign win_r[1] = lb0[in_col];
  assign win_r[2] = pix;

  always_comb begin
    logic [PIXEL_BITS-1:0] tap;
    logic                  pad;
    sum = '0;
    tap = '0;
    pad = 1'b0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        tap = (c == 0) ? win_l[r] : (c == 1) ? win_c[r] : win_r[r];
        // Padding follows the output coordinate so wrapped line data never leaks in.
        pad = (r == 0 && out_row == '0) || (r == 2 && out_row == RW'(IMG_H - 1)) ||
              (c == 0 && out_col == '0) || (c == 2 && out_col == CW'(IMG_W - 1));
        if (pad) tap = '0;
        sum = sum + SW'($signed({1'b0, tap})) * SW'(coef[r*3+c]);
      end
    end
    res = sum >>> SHIFT;
    if (res < 0)                sat = '0;
    else if (res > SW'(PMAX))   sat = '1;
    else                        sat = res[PIXEL_BITS-1:0];
  end

  always_ff @(posedge clk) begin
    if (step) begin
      lb0[in_col] <= pix;
      lb1[in_col] <= lb0[in_col];
      for (int r = 0; r < 3; r++) begin
        win_l[r] <= win_c[r];
        win_c[r] <= win_r[r];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      in_col  <= '0;
      in_row  <= '0;
      out_col <= '0;
      out_row <= '0;
      fill    <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
      for (int i = 0; i < 9; i++) coef[i] <= COEF_BITS'(SOBEL_X[i]);
    end else begin
      if (coef_we && coef_addr < 4'd9) coef[coef_addr] <= coef_data;
      if (step) begin
        if (in_col == CW'(IMG_W - 1)) begin
          in_col <= '0;
          if (state == RUN) in_row <= (in_row == RW'(IMG_H - 1)) ? '0 : in_row + 1'b1;
        end else begin
          in_col <= in_col + 1'b1;
        end
        if (state == RUN && in_last) state <= FLUSH;
        if (fill != FW'(IMG_W + 1)) fill <= fill + 1'b1;
      end
      if (produce) begin
        if (out_col == CW'(IMG_W - 1)) begin
          out_col <= '0;
          out_row <= (out_row == RW'(IMG_H - 1)) ? '0 : out_row + 1'b1;
        end else begin
          out_col <= out_col + 1'b1;
        end
        // Frame complete: realign the column counter that kept running through the flush.
        if (out_last) begin
          state  <= RUN;
          fill   <= '0;
          in_col <= '0;
        end
      end
      if (adv) begin
        m_valid <= produce;
        m_last  <= produce && out_last;
      end
      if (produce) m_data <= sat;
    end
  end
endmodule

// File: tb/tb_conv2d_3x3_stream.sv
// tb/tb_conv2d_3x3_stream.sv - scoreboard bench for conv2d_3x3_stream on a 4x3 image
// Two instances (SHIFT 0 and 4) share stimulus; expectations come from a direct 2D convolution model.
module tb_conv2d_3x3_stream;
  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  typedef struct {
    int sum;
    bit last;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = '0;
  logic       coef_we = 1'b0;
  logic [3:0] coef_addr = '0;
  logic [7:0] coef_data = '0;
  logic       m_ready = 1'b1;
  logic       s_ready0, m_valid0, m_last0, s_ready1, m_valid1, m_last1;
  logic [7:0] m_data0, m_data1;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   img [H][W];
  int   k [9];
  int   stall_cnt = 0;
  bit   bp = 1'b0;
  int   first_wait = 0;

  conv2d_3x3_stream #(.IMG_W(W), .IMG_H(H), .PIXEL_BITS(8), .COEF_BITS(8), .SHIFT(0)) dut0 (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready0), .s_data(s_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .m_valid(m_valid0), .m_ready(m_ready), .m_data(m_data0), .m_last(m_last0)
  );

  conv2d_3x3_stream #(.IMG_W(W), .IMG_H(H), .PIXEL_BITS(8), .COEF_BITS(8), .SHIFT(4)) dut1 (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready1), .s_data(s_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .m_valid(m_valid1), .m_ready(m_ready), .m_data(m_data1), .m_last(m_last1)
  );

  always #5 clk = ~clk;

  function automatic int sat(input int s, input int sh);
    int v;
    v = s >>> sh;
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_expected();
    exp_t e;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        int s;
        s = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if (r + dr >= 0 && r + dr < H && c + dc >= 0 && c + dc < W)
              s += k[(dr + 1) * 3 + (dc + 1)] * img[r + dr][c + dc];
        e.sum  = s;
        e.last = (r == H - 1) && (c == W - 1);
        q.push_back(e);
      end
    end
  endtask

  task automatic send_image(input int n, input int stall_after);
    for (int i = 0; i < n; i++) begin
      int waited;
      bit acc;
      waited  = 0;
      s_valid = 1'b1;
      s_data  = 8'(img[i / W][i % W]);
      forever begin
        @(negedge clk);
        acc = s_ready0;
        @(posedge clk);
        #1;
        if (acc) break;
        waited++;
        if (waited > 200) begin
          check("s_ready_timeout", 0, 1);
          s_valid = 1'b0;
          return;
        end
      end
      if (i == 0) first_wait = waited;
      if (i + 1 == stall_after) stall_cnt = 5;
    end
  endtask

  task automatic load_kernel();
    for (int i = 0; i < 16; i++) begin
      coef_we   = 1'b1;
      coef_addr = 4'(i);
      coef_data = (i < 9) ? 8'(k[i]) : 8'($urandom);
      @(posedge clk);
      #1;
    end
    coef_we = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("drain", q.size(), 0);
  endtask

  task automatic random_image();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = int'($urandom_range(0, 255));
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    if (stall_cnt > 0) begin
      m_ready = 1'b0;
      stall_cnt--;
    end else begin
      m_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  initial begin
    bit         prev_stall;
    logic [7:0] prev_d0, prev_d1;
    logic       prev_l;
    exp_t       e;
    prev_stall = 1'b0;
    prev_d0 = '0;
    prev_d1 = '0;
    prev_l = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        q.delete();
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", int'(m_valid0), 1);
          check("hold_data", int'(m_data0), int'(prev_d0));
          check("hold_data_sh4", int'(m_data1), int'(prev_d1));
          check("hold_last", int'(m_last0), int'(prev_l));
        end
        if (m_valid0 && !m_ready) check("s_ready_in_stall", int'(s_ready0), 0);
        if (m_valid0 && m_ready) begin
          if (q.size() == 0) begin
            check("unexpected_output", 1, 0);
          end else begin
            e = q.pop_front();
            check("data_shift0", int'(m_data0), sat(e.sum, 0));
            check("last", int'(m_last0), int'(e.last));
            check("valid_shift4", int'(m_valid1), 1);
            check("data_shift4", int'(m_data1), sat(e.sum, 4));
          end
        end
        prev_stall = m_valid0 && !m_ready;
        prev_d0    = m_data0;
        prev_d1    = m_data1;
        prev_l     = m_last0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, got timeout, expected finish");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_m_valid", int'(m_valid0), 0);
    check("rst_m_data", int'(m_data0), 0);
    check("rst_m_last", int'(m_last0), 0);
    check("rst_s_ready", int'(s_ready0), 1);
    @(posedge clk);
    #1;

    // Reset-default Sobel-x on a column ramp
    k = '{1, 0, -1, 2, 0, -2, 1, 0, -1};
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = c * 64;
    push_expected();
    send_image(N, 0);
    s_valid = 1'b0;
    wait_drain();

    // Identity kernel on a 0..11 ramp
    k = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    load_kernel();
    for (int i = 0; i < N; i++) img[i / W][i % W] = i;
    push_expected();
    send_image(N, 0);
    s_valid = 1'b0;
    wait_drain();

    // All-ones kernel, constant 10 then constant 50
    k = '{default: 1};
    load_kernel();
    for (int i = 0; i < N; i++) img[i / W][i % W] = 10;
    push_expected();
    send_image(N, 0);
    s_valid = 1'b0;
    wait_drain();
    for (int i = 0; i < N; i++) img[i / W][i % W] = 50;
    push_expected();
    send_image(N, 0);
    s_valid = 1'b0;
    wait_drain();

    // Identity ramp with a 5-cycle downstream stall mid-frame
    k = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    load_kernel();
    for (int i = 0; i < N; i++) img[i / W][i % W] = i;
    push_expected();
    send_image(N, 7);
    s_valid = 1'b0;
    wait_drain();

    // Reset mid-frame with a colliding coefficient write
    random_image();
    push_expected();
    send_image(7, 0);
    s_valid   = 1'b0;
    rst       = 1'b1;
    coef_we   = 1'b1;
    coef_addr = 4'd0;
    coef_data = 8'd5;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    coef_we = 1'b0;
    @(negedge clk);
    check("post_rst_m_valid", int'(m_valid0), 0);
    check("post_rst_s_ready", int'(s_ready0), 1);
    check("post_rst_m_last", int'(m_last0), 0);
    @(posedge clk);
    #1;
    k = '{1, 0, -1, 2, 0, -2, 1, 0, -1};
    random_image();
    push_expected();
    send_image(N, 0);
    s_valid = 1'b0;
    wait_drain();

    // Back-to-back frames with s_valid held high
    random_image();
    push_expected();
    send_image(N, 0);
    random_image();
    push_expected();
    send_image(N, 0);
    s_valid = 1'b0;
    check("flush_gap", first_wait, W + 1);
    wait_drain();

    // Random kernels and images under random backpressure
    bp = 1'b1;
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < 9; i++)
        k[i] = (f % 2 == 1) ? int'($urandom_range(0, 255)) - 128 : int'($urandom_range(0, 8)) - 4;
      load_kernel();
      random_image();
      push_expected();
      send_image(N, 0);
      s_valid = 1'b0;
      wait_drain();
    end
    bp = 1'b0;

    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
